toast_mem_arbiter: RTL

- Two-requester arbiter sharing one synchronous single-port 32-bit RAM.
- M0 is the ToastCore data/fetch memory port. M1 is a loader/debug master that writes riscv-tests images and reads back `tohost` without removing the core.
- Round-robin on contention. M1 may lock the port for contiguous image loads.
- Counts M0 stall cycles for test-harness performance reporting.

---
 rtl/toast_mem_arbiter_pkg.sv | 28 ++
 rtl/toast_rr_arb2.sv | 51 +++++
 rtl/toast_mem_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/toast_mem_arbiter_pkg.sv
// rtl/toast_mem_arbiter_pkg.sv - shared types and constants for the ToastCore memory arbiter
package toast_mem_arbiter_pkg;

  // Native RAM word-address width; the top defaults its AW to this.
  localparam int REQ_AW = 16;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [3:0]        be;
    logic [REQ_AW-1:0] addr;
    logic [31:0]       wdata;
  } mem_req_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
  } mem_rsp_t;

  // Byte write strobes for a request: reads never touch RAM contents.
  function automatic logic [3:0] write_strobe(input mem_req_t r);
    return r.we ? r.be : 4'b0000;
  endfunction

endpackage

// File: rtl/toast_rr_arb2.sv
// rtl/toast_rr_arb2.sv - two-way round-robin grant with an M1-held lock
import toast_mem_arbiter_pkg::*;

module toast_rr_arb2 (
  input  logic clk,
  input  logic resetn,
  input  logic req0,
  input  logic req1,
  input  logic lock1,
  output logic gnt0,
  output logic gnt1
);

  logic last_owner;
  logic locked;
  logic lock_hold;

  // Dropping lock1 releases the port in the same cycle, not one cycle later.
  assign lock_hold = locked & lock1;

  // Grant decision: lock first, then a lone requester, then round-robin.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (resetn) begin
      if (lock_hold) begin
        gnt1 = req1;
      end else if (req0 && req1) begin
        if (last_owner == OWNER_M0) gnt1 = 1'b1;
        else                        gnt0 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Track the most recent owner and whether M1 has taken the lock.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_owner <= OWNER_M1;
      locked     <= 1'b0;
    end else begin
      if (gnt0)      last_owner <= OWNER_M0;
      else if (gnt1) last_owner <= OWNER_M1;
      if (!lock1)    locked <= 1'b0;
      else if (gnt1) locked <= 1'b1;
    end
  end

endmodule

// File: rtl/toast_mem_arbiter.sv
// rtl/toast_mem_arbiter.sv - ToastCore / loader arbiter for one single-port 32-bit RAM
import toast_mem_arbiter_pkg::*;

module toast_mem_arbiter #(
  parameter int AW    = REQ_AW,
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [3:0]       m0_be,
  input  logic [AW-1:0]    m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [31:0]      m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [3:0]       m1_be,
  input  logic [AW-1:0]    m1_addr,
  input  logic [31:0]      m1_wdata,
  input  logic             m1_lock,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [31:0]      m1_rdata,
  output logic             mem_en,
  output logic [3:0]       mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] m0_stall_cnt
);

  mem_req_t m0_r, m1_r, sel_r;
  mem_rsp_t m0_rsp, m1_rsp;
  logic     rsp_valid;
  logic     rsp_owner;
  logic     rsp_is_read;

  // Pack each master's request; the RAM side is driven from M0 when idle.
  always_comb begin
    m0_r       = '0;
    m0_r.req   = m0_req;
    m0_r.we    = m0_we;
    m0_r.be    = m0_be;
    m0_r.addr  = REQ_AW'(m0_addr);
    m0_r.wdata = m0_wdata;
    m1_r       = '0;
    m1_r.req   = m1_req;
    m1_r.we    = m1_we;
    m1_r.be    = m1_be;
    m1_r.addr  = REQ_AW'(m1_addr);
    m1_r.wdata = m1_wdata;
    sel_r      = m1_gnt ? m1_r : m0_r;
  end

  toast_rr_arb2 u_arb (
    .clk    (Clk),
    .resetn (Reset_n),
    .req0   (m0_req),
    .req1   (m1_req),
    .lock1  (m1_lock),
    .gnt0   (m0_gnt),
    .gnt1   (m1_gnt)
  );

  assign mem_en    = (m0_gnt | m1_gnt) & sel_r.req;
  assign mem_we    = mem_en ? write_strobe(sel_r) : 4'b0000;
  assign mem_addr  = sel_r.addr[AW-1:0];
  assign mem_wdata = sel_r.wdata;

  // One-deep response pipeline: remember who was granted and whether it read.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rsp_valid   <= 1'b0;
      rsp_owner   <= OWNER_M0;
      rsp_is_read <= 1'b0;
    end else begin
      rsp_valid   <= mem_en;
      rsp_owner   <= m1_gnt ? OWNER_M1 : OWNER_M0;
      rsp_is_read <= ~sel_r.we;
    end
  end

  // Steer the response to its owner; writes return zero data as an ack.
  // Gated by Reset_n so a response in flight when reset hits is never seen.
  always_comb begin
    m0_rsp = '0;
    m1_rsp = '0;
    if (Reset_n && rsp_valid) begin
      if (rsp_owner == OWNER_M0) begin
        m0_rsp.rvalid = 1'b1;
        m0_rsp.rdata  = rsp_is_read ? mem_rdata : 32'h0;
      end else begin
        m1_rsp.rvalid = 1'b1;
        m1_rsp.rdata  = rsp_is_read ? mem_rdata : 32'h0;
      end
    end
  end

  assign m0_rvalid = m0_rsp.rvalid;
  assign m0_rdata  = m0_rsp.rdata;
  assign m1_rvalid = m1_rsp.rvalid;
  assign m1_rdata  = m1_rsp.rdata;

  // Saturating count of cycles the core wanted the RAM but did not get it.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      m0_stall_cnt <= '0;
    end else if (m0_req && !m0_gnt && (m0_stall_cnt != {CNT_W{1'b1}})) begin
      m0_stall_cnt <= m0_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
